// File: rtl/lsu_data_ram.sv
// ============================================================================
//  Module   : lsu_data_ram
//  Brief    : Byte-addressed single-port data memory for the load/store path.
//             Byte/half/word stores with internal lane strobes, sign/zero
//             extending loads, misalignment detection, valid/ready request
//             channel and an in-order response pipeline of READ_LAT stages.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_data_ram #(
  parameter int DEPTH    = 128,
  parameter int ADDR_W   = $clog2(DEPTH) + 2,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_unsigned_i,
  input  logic [31:0]       req_wdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int IDX_W = ADDR_W - 2;

  logic [31:0] mem [DEPTH];

  logic              accept;
  logic              req_err;
  logic [IDX_W-1:0]  word_idx;
  logic [3:0]        lane_en;
  logic [31:0]       wr_word;
  logic [31:0]       rd_word;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [31:0]       load_data;

  logic [READ_LAT-1:0]       vld_d,   vld_q;
  logic [READ_LAT-1:0]       err_d,   err_q;
  logic [READ_LAT-1:0][31:0] rdata_d, rdata_q;

  // The block never stalls; it is only unavailable while held in reset.
  assign req_ready_o = !rst;
  assign accept      = req_valid_i && req_ready_o;
  assign word_idx    = req_addr_i[ADDR_W-1:2];

  // Decode the access: alignment/size error, lane strobes, replicated store
  // data, and extraction/extension of the addressed load bytes.
  always_comb begin
    req_err  = 1'b0;
    lane_en  = 4'b0000;
    wr_word  = req_wdata_i;
    rd_word  = mem[word_idx];
    byte_sel = rd_word[7:0];
    half_sel = rd_word[15:0];
    load_data = rd_word;

    case (req_size_i)
      2'd0: begin
        lane_en = 4'b0001 << req_addr_i[1:0];
        wr_word = {4{req_wdata_i[7:0]}};
      end
      2'd1: begin
        req_err = req_addr_i[0];
        lane_en = req_addr_i[1] ? 4'b1100 : 4'b0011;
        wr_word = {2{req_wdata_i[15:0]}};
      end
      2'd2: begin
        req_err = (req_addr_i[1:0] != 2'd0);
        lane_en = 4'b1111;
      end
      default: begin
        req_err = 1'b1;
      end
    endcase
    // An erroring store must leave memory untouched.
    if (req_err) begin
      lane_en = 4'b0000;
    end

    case (req_addr_i[1:0])
      2'd0:    byte_sel = rd_word[7:0];
      2'd1:    byte_sel = rd_word[15:8];
      2'd2:    byte_sel = rd_word[23:16];
      default: byte_sel = rd_word[31:24];
    endcase
    half_sel = req_addr_i[1] ? rd_word[31:16] : rd_word[15:0];

    case (req_size_i)
      2'd0:    load_data = req_unsigned_i ? {24'd0, byte_sel}
                                          : {{24{byte_sel[7]}}, byte_sel};
      2'd1:    load_data = req_unsigned_i ? {16'd0, half_sel}
                                          : {{16{half_sel[15]}}, half_sel};
      default: load_data = rd_word;
    endcase
  end

  // Stage 1 captures the new response; later stages are plain shifts.
  // rdata/err in stage 1 hold their last value when nothing is accepted.
  always_comb begin
    vld_d   = vld_q;
    err_d   = err_q;
    rdata_d = rdata_q;

    vld_d[0] = accept;
    if (accept) begin
      err_d[0]   = req_err;
      rdata_d[0] = (!req_we_i && !req_err) ? load_data : 32'd0;
    end

    for (int s = 1; s < READ_LAT; s++) begin
      vld_d[s]   = vld_q[s-1];
      err_d[s]   = err_q[s-1];
      rdata_d[s] = rdata_q[s-1];
    end
  end

  // Response pipeline registers; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      err_q   <= '0;
      rdata_q <= '0;
    end else begin
      vld_q   <= vld_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage array: per-lane write at the accept edge, no reset.
  always_ff @(posedge clk) begin
    if (accept && req_we_i) begin
      for (int l = 0; l < 4; l++) begin
        if (lane_en[l]) begin
          mem[word_idx][8*l +: 8] <= wr_word[8*l +: 8];
        end
      end
    end
  end

  // A response sitting in the last stage while reset is asserted is part of
  // the in-flight state being discarded, so it is masked as well.
  assign rsp_valid_o = vld_q[READ_LAT-1] && !rst;
  assign rsp_rdata_o = rdata_q[READ_LAT-1];
  assign rsp_err_o   = err_q[READ_LAT-1];

endmodule

`default_nettype wire

// File: tb/tb_lsu_data_ram.sv
// ============================================================================
//  Module   : tb_lsu_data_ram
//  Brief    : Scoreboard bench driving two instances (READ_LAT 1 and 3) with
//             identical stimulus against a byte-array reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_data_ram;

  localparam int DEPTH  = 128;
  localparam int ADDR_W = $clog2(DEPTH) + 2;

  typedef struct {
    int          due;
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_we = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [1:0]        req_size = 2'd0;
  logic              req_uns = 1'b0;
  logic [31:0]       req_wdata = '0;

  logic        rdy1, vld1, err1;
  logic [31:0] dat1;
  logic        rdy3, vld3, err3;
  logic [31:0] dat3;

  int   n_checks = 0;
  int   n_fails  = 0;
  int   neg_cnt  = 0;
  exp_t q1[$];
  exp_t q3[$];
  logic [7:0] mb [DEPTH*4];

  always #5 clk = ~clk;

  lsu_data_ram #(.DEPTH(DEPTH), .READ_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(rdy1),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_size_i(req_size),
    .req_unsigned_i(req_uns), .req_wdata_i(req_wdata),
    .rsp_valid_o(vld1), .rsp_rdata_o(dat1), .rsp_err_o(err1)
  );

  lsu_data_ram #(.DEPTH(DEPTH), .READ_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(rdy3),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_size_i(req_size),
    .req_unsigned_i(req_uns), .req_wdata_i(req_wdata),
    .rsp_valid_o(vld3), .rsp_rdata_o(dat3), .rsp_err_o(err3)
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int qsz(int lat);
    return (lat == 1) ? q1.size() : q3.size();
  endfunction

  function automatic exp_t qfr(int lat);
    return (lat == 1) ? q1[0] : q3[0];
  endfunction

  function automatic void qpop(int lat);
    if (lat == 1) void'(q1.pop_front());
    else          void'(q3.pop_front());
  endfunction

  function automatic void qflush(int lat);
    if (lat == 1) q1.delete();
    else          q3.delete();
  endfunction

  // Reference model: byte-granular memory, result computed from the access rules.
  function automatic void model(input logic we, input logic [ADDR_W-1:0] addr,
                                input logic [1:0] size, input logic uns,
                                input logic [31:0] wd,
                                output logic [31:0] d, output logic e);
    int          n;
    int          base;
    logic [31:0] val;
    e = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
        (size == 2'd2 && addr[1:0] != 2'd0);
    d = 32'd0;
    if (e) return;
    n    = 1 << size;
    base = int'(addr);
    if (we) begin
      for (int b = 0; b < n; b++) mb[base + b] = wd[8*b +: 8];
    end else begin
      val = 32'd0;
      for (int b = 0; b < n; b++) val[8*b +: 8] = mb[base + b];
      if (n == 4)      d = val;
      else if (uns)    d = val;
      else if (n == 1) d = val[7]  ? (val | 32'hFFFF_FF00) : val;
      else             d = val[15] ? (val | 32'hFFFF_0000) : val;
    end
  endfunction

  task automatic mon(input int lat, input logic v, input logic [31:0] d,
                     input logic e);
    exp_t x;
    if (rst) begin
      chk($sformatf("lat%0d_no_rsp_in_reset", lat), {31'd0, v}, 32'd0);
      qflush(lat);
      return;
    end
    while (qsz(lat) > 0 && qfr(lat).due < neg_cnt) begin
      x = qfr(lat);
      n_checks++;
      n_fails++;
      $display("FAIL lat%0d_missing_rsp: no response seen, expected data %h err %0d",
               lat, x.d, x.e);
      qpop(lat);
    end
    if (v) begin
      if (qsz(lat) == 0 || qfr(lat).due != neg_cnt) begin
        n_checks++;
        n_fails++;
        $display("FAIL lat%0d_unexpected_rsp: got data %h err %0d, expected none",
                 lat, d, e);
      end else begin
        x = qfr(lat);
        qpop(lat);
        chk($sformatf("lat%0d_rdata", lat), d, x.d);
        chk($sformatf("lat%0d_err", lat), {31'd0, e}, {31'd0, x.e});
      end
    end
  endtask

  // Monitor: sample both instances away from the active edge.
  always @(negedge clk) begin
    neg_cnt++;
    mon(1, vld1, dat1, err1);
    mon(3, vld3, dat3, err3);
  end

  task automatic do_req(input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [1:0] size, input logic uns,
                        input logic [31:0] wd);
    exp_t x;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_size  = size;
    req_uns   = uns;
    req_wdata = wd;
    @(posedge clk);
    model(we, addr, size, uns, wd, x.d, x.e);
    x.due = neg_cnt + 1;
    q1.push_back(x);
    x.due = neg_cnt + 3;
    q3.push_back(x);
    #1 req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("ready1_in_reset", {31'd0, rdy1}, 32'd0);
    chk("ready3_in_reset", {31'd0, rdy3}, 32'd0);
    chk("rdata1_after_reset", dat1, 32'd0);
    chk("rdata3_after_reset", dat3, 32'd0);
    chk("err1_after_reset", {31'd0, err1}, 32'd0);
    chk("err3_after_reset", {31'd0, err3}, 32'd0);
    rst = 1'b0;
    #1;
    chk("ready1_after_reset", {31'd0, rdy1}, 32'd1);
    chk("ready3_after_reset", {31'd0, rdy3}, 32'd1);
    chk("valid1_after_reset", {31'd0, vld1}, 32'd0);
    chk("valid3_after_reset", {31'd0, vld3}, 32'd0);

    // Define every word so model and array agree from here on
    for (int i = 0; i < DEPTH; i++)
      do_req(1'b1, ADDR_W'(i * 4), 2'd2, 1'b0, $urandom);
    idle(4);

    // Word round trip
    do_req(1'b1, 9'h010, 2'd2, 1'b0, 32'h1234_5678);
    do_req(1'b0, 9'h010, 2'd2, 1'b0, 32'd0);
    idle(4);

    // Sub-word stores and extending loads
    do_req(1'b1, 9'h020, 2'd2, 1'b0, 32'h0000_0000);
    do_req(1'b1, 9'h022, 2'd0, 1'b0, 32'h0000_0080);
    do_req(1'b1, 9'h020, 2'd1, 1'b0, 32'h0000_BEEF);
    do_req(1'b0, 9'h020, 2'd2, 1'b0, 32'd0);
    do_req(1'b0, 9'h022, 2'd0, 1'b0, 32'd0);
    do_req(1'b0, 9'h022, 2'd0, 1'b1, 32'd0);
    do_req(1'b0, 9'h020, 2'd1, 1'b0, 32'd0);
    do_req(1'b0, 9'h020, 2'd1, 1'b1, 32'd0);
    idle(4);

    // Misalignment and illegal size
    do_req(1'b1, 9'h030, 2'd2, 1'b0, 32'hAAAA_AAAA);
    do_req(1'b1, 9'h031, 2'd1, 1'b0, 32'h1111_1111);
    do_req(1'b1, 9'h032, 2'd2, 1'b0, 32'h2222_2222);
    do_req(1'b1, 9'h030, 2'd3, 1'b0, 32'h3333_3333);
    do_req(1'b0, 9'h033, 2'd2, 1'b0, 32'd0);
    do_req(1'b0, 9'h030, 2'd2, 1'b0, 32'd0);
    idle(4);

    // Throughput: preload words 0..7 then 8 back-to-back loads
    for (int i = 0; i < 8; i++)
      do_req(1'b1, ADDR_W'(i * 4), 2'd2, 1'b0, 32'h1111_1111 * i);
    for (int i = 0; i < 8; i++)
      do_req(1'b0, ADDR_W'(i * 4), 2'd2, 1'b0, 32'd0);
    // Store immediately followed by load of the same word
    do_req(1'b1, 9'h00C, 2'd2, 1'b0, 32'hCAFE_F00D);
    do_req(1'b0, 9'h00C, 2'd2, 1'b0, 32'd0);
    do_req(1'b1, 9'h00D, 2'd0, 1'b0, 32'h0000_0042);
    do_req(1'b0, 9'h00C, 2'd2, 1'b0, 32'd0);
    idle(5);

    // Reset while responses are in flight
    do_req(1'b0, 9'h044, 2'd2, 1'b0, 32'd0);
    do_req(1'b1, 9'h040, 2'd2, 1'b0, 32'h5A5A_5A5A);
    do_req(1'b0, 9'h040, 2'd2, 1'b0, 32'd0);
    rst       = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 9'h040;
    req_size  = 2'd2;
    req_wdata = 32'hDEAD_BEEF;
    #1;
    chk("ready1_during_rst", {31'd0, rdy1}, 32'd0);
    chk("ready3_during_rst", {31'd0, rdy3}, 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = 1'b0;
    idle(5);
    do_req(1'b0, 9'h040, 2'd2, 1'b0, 32'd0);
    idle(4);

    // Highest word, and word 0 untouched
    do_req(1'b1, 9'h1FC, 2'd2, 1'b0, 32'h0BAD_F00D);
    do_req(1'b0, 9'h1FC, 2'd2, 1'b0, 32'd0);
    do_req(1'b0, 9'h000, 2'd2, 1'b0, 32'd0);
    idle(4);

    // Randomized traffic with occasional idle cycles
    for (int i = 0; i < 600; i++) begin
      logic [ADDR_W-1:0] a;
      if ($urandom_range(0, 4) == 0) idle(1);
      a = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(0, DEPTH*4-1))
                                      : ADDR_W'($urandom_range(0, 31));
      do_req(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom);
    end

    idle(8);
    chk("lat1_all_rsp_drained", 32'(qsz(1)), 32'd0);
    chk("lat3_all_rsp_drained", 32'(qsz(3)), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lsu_data_ram.md
Name: lsu_data_ram

Overview:
- Parametrised single-port data memory for the RISC-V core's load/store path. Next generation of the plain word-addressed RAM.
- Adds the following over that RAM:
  - byte addressing;
  - byte, half and word stores, using lane strobes generated internally;
  - sign- and zero-extending loads;
  - misalignment detection;
  - a valid/ready request channel;
  - a response pipeline of configurable latency.
- Sits between the MEM stage and the backing storage array. Responses return strictly in order.

Parameters:
- DEPTH, 128, number of 32-bit words; must be a power of 2, minimum 4.
- ADDR_W, $clog2(DEPTH)+2, byte-address width (derived; not to be overridden).
- READ_LAT, 1, cycles from request acceptance to response valid; legal range 1..4.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  block can accept a request this cycle.
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  ADDR_W  byte address.
- req_size_i  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned_i  in  1  load zero-extends (LBU/LHU); ignored for stores and for word loads.
- req_wdata_i  in  32  store data, right-aligned (the byte is in [7:0], the half in [15:0]).
- rsp_valid_o  out  1  response valid for one cycle.
- rsp_rdata_o  out  32  load result, already extended; 0 for stores and for errors.
- rsp_err_o  out  1  access was misaligned or had an illegal size.

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset:
  - While rst is high at a clock edge: all pipeline valid bits, rsp_valid_o, rsp_err_o and rsp_rdata_o clear to 0.
  - Memory contents are not reset.
  - req_ready_o is 0 while rst is high and 1 in every other cycle. There is no response backpressure, so the block is fully pipelined.
- Accept: a request is accepted in a cycle when req_valid_i && req_ready_o. At most one request per cycle.
- Error check, performed on the accept cycle:
  - size 3 is an error;
  - half with addr[0] = 1 is an error;
  - word with addr[1:0] != 0 is an error.
  - An erroring store does not modify memory. An erroring load returns rdata 0. Both give rsp_err_o = 1.
- Word index: addr[ADDR_W-1:2]. Byte lane: addr[1:0].
- Store:
  - Byte: wdata[7:0] is written to lane addr[1:0].
  - Half: wdata[15:0] is written to lanes {addr[1],0} and {addr[1],1}.
  - Word: all 4 lanes are written.
  - Other lanes are untouched.
  - The write commits at the accept edge.
  - A store still produces a response: rsp_valid_o = 1, rdata 0, err as computed.
- Load:
  - The array is read at the accept edge, and the requested byte or half is extracted using the captured addr[1:0] and size.
  - Result: sign-extended from bit 7 or 15, or zero-extended if req_unsigned_i is set.
- Ordering:
  - A load accepted the cycle after a store to the same word returns the post-store data.
  - Back-to-back requests are accepted every cycle, with no bubbles.
- Latency: the response for a request accepted at edge N appears with rsp_valid_o high during the cycle after edge N+READ_LAT-1. Concretely, READ_LAT = 1 means the response is valid in the cycle immediately after acceptance.
- Pipeline: READ_LAT stages, each holding {valid, err, rdata}. Stage 1 is loaded from the array read and extract/extend logic. Stages 2..READ_LAT are plain shift registers.
- Reset mid-operation:
  - All in-flight responses are discarded and never appear.
  - Stores already committed before the reset edge remain in memory.
  - A request presented while rst is high is not accepted (ready is 0) and does not write.
- Idle: when no request is accepted, the stage-1 valid bit is 0. rsp_rdata_o holds its previous value but must be ignored while rsp_valid_o = 0.

Test Plan:
- Word round trip, READ_LAT = 1: SW 0x12345678 to addr 0x10, then LW from 0x10 → one cycle after the LW is accepted, rsp_valid_o = 1, rdata 0x12345678, err 0. The store response (rdata 0, err 0) appears on the cycle before it.
- Sub-word stores/loads: SW 0x00000000 to 0x20; SB 0x80 to 0x22; SH 0xBEEF to 0x20 → LW 0x20 returns 0x0080BEEF. LB 0x22 returns 0xFFFFFF80. LBU 0x22 returns 0x00000080. LH 0x20 returns 0xFFFFBEEF. LHU 0x20 returns 0x0000BEEF.
- Misalignment and illegal size:
  - SW 0xAAAAAAAA to 0x30;
  - SH to 0x31 → err 1;
  - SW to 0x32 → err 1;
  - size 3 to 0x30 → err 1;
  - LW 0x30 → returns 0xAAAAAAAA, err 0 (memory unchanged).
- Latency and throughput, READ_LAT = 3: 8 back-to-back LWs to words 0..7 (preloaded with the values i*0x11111111) → 8 consecutive rsp_valid_o pulses, the first 3 cycles after the first accept, data in order. A store followed immediately by a load to the same word returns the new data.
- Reset mid-flight, READ_LAT = 3:
  - issue an LW, then SW 0x5A5A5A5A to 0x40, then an LW;
  - assert rst for one cycle on the cycle after the last accept;
  - → none of the in-flight responses appear;
  - req_ready_o = 0 during rst;
  - a later LW 0x40 returns 0x5A5A5A5A.
- Wrap/high address, DEPTH = 128: SW to byte addr 0x1FC → LW 0x1FC returns the same value; word 0 is unchanged.
